multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
- Sequences the shared iterative multiply/divide unit for the 5-stage pipeline.
- Accepts a mul/div from the DX stage and latches its operands and destination register.
- Pulses the unit's start control and freezes the front of the pipeline (PC/FD/DX) until the result is ready.
- Arbitrates for the regfile write port, writing the result to rd or an exception code to rstatus.

Parameters:
TIMEOUT_CYCLES, 40, WAIT-state cycles with no md_ready before a forced exception.
CNT_W, 6, width of the WAIT cycle counter; must hold TIMEOUT_CYCLES.
RSTATUS_REG, 30, register written on exception.
MUL_EXC_CODE, 4, rstatus value for a mult exception or timeout.
DIV_EXC_CODE, 5, rstatus value for a div exception or timeout.

Ports:
clock  in  1  master clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high.
issue_valid  in  1  DX holds a mul/div instruction.
issue_is_div  in  1  1=div, 0=mult.
issue_a  in  32  bypassed operand A.
issue_b  in  32  bypassed operand B.
issue_rd  in  5  destination register.
flush  in  1  abort the in-flight operation.
md_ctrl_mult  out  1  one-cycle start pulse to the unit (mult).
md_ctrl_div  out  1  one-cycle start pulse to the unit (div).
md_operand_a  out  32  latched operand A, held stable while busy.
md_operand_b  out  32  latched operand B, held stable while busy.
md_result  in  32  unit result.
md_exception  in  1  unit exception; valid with md_ready.
md_ready  in  1  unit result-ready.
stall  out  1  freeze PC/FD/DX and inject a nop into XM.
wb_valid  out  1  request for the regfile write port.
wb_reg  out  5  write register.
wb_data  out  32  write data.
wb_accept  in  1  write port granted this cycle.
retire  out  1  one-cycle pulse; pipeline replaces the DX mul/div with a nop and advances.
busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, START, WAIT, WB.
- Reset: state=IDLE; counter, latches, md_operand_a/b, wb_reg, wb_data = 0; all 1-bit outputs 0. Reset overrides flush and every other input.

IDLE
- If issue_valid: on the next edge latch a, b, rd and op, then go to START.
- stall = issue_valid, combinationally in the same cycle, so DX holds.

START
- Assert exactly one of md_ctrl_mult/md_ctrl_div for this cycle only.
- Clear the counter; go to WAIT. md_ready is ignored in START.

WAIT
- Counter increments each cycle.
- If md_ready: capture md_result and md_exception, go to WB.
- Else if counter == TIMEOUT_CYCLES-1: set the exception flag, go to WB.

WB
- Exception: wb_valid=1, wb_reg=RSTATUS_REG, wb_data=MUL/DIV_EXC_CODE zero-extended to 32 bits.
- No exception and rd!=0: wb_valid=1, wb_reg=rd, wb_data=result.
- No exception and rd==0: wb_valid=0.
- retire = wb_accept | ~wb_valid. On retire go to IDLE.
- wb_reg and wb_data stay stable while waiting for wb_accept.

Stall, busy and issue rules
- stall is 1 in START, in WAIT, and in WB except the retire cycle (stall=0 when retire=1).
- busy=1 in START, WAIT and WB.
- issue_valid is ignored outside IDLE, including during the retire cycle.

Latency
- Issue seen in cycle N: ctrl pulse in N+1, WAIT from N+2.
- md_ready in cycle R: wb_valid in R+1.
- Minimum issue-to-retire is 3 cycles after the ready cycle count.

flush
- In START, WAIT or WB: go to IDLE on the next edge; no retire, no write.
- In the same cycle, ctrl pulse, wb_valid and stall are forced to 0.
- Flush wins over a simultaneous md_ready or wb_accept.
- A stale md_ready that arrives later in IDLE is ignored.
- A new START pulse restarts the unit.

Other rules
- Mid-operation reset behaves the same as flush and also clears all latches.
- Unsigned counter; no wrap, because the timeout fires first.

Test Plan:
1. Issue mult a=7, b=-3, rd=5; md_ready 33 cycles after the pulse; wb_accept=1 -> a single md_ctrl_mult pulse in cycle N+1; stall high through WAIT; wb_reg=5, wb_data=0xFFFFFFEB; one retire pulse; stall low in the retire cycle.
2. Div a=100, b=0; md_exception=1 with md_ready -> wb_reg=30, wb_data=5; no write to rd.
3. Mult result ready with wb_accept held low 3 cycles -> wb_valid, wb_reg and wb_data stable for 3 cycles, stall=1; retire and IDLE in the accept cycle.
4. Mult issued, md_ready never asserted -> after 40 WAIT cycles WB with wb_reg=30, wb_data=4.
5. flush in WAIT cycle 10, then md_ready 5 cycles later, then a new div issue -> IDLE next cycle; no wb_valid or retire; the stale ready is ignored; md_ctrl_div pulses once with the new operands.
6. Mult with rd=0 -> wb_valid never asserted; retire in the first WB cycle. Repeat with reset in WAIT -> all outputs 0 the next cycle; state IDLE.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences the shared iterative multiply/divide unit.
// Latches a mul/div from DX, pulses the unit start, freezes the front of the
// pipeline while the unit works, then arbitrates for the regfile write port to
// write the result (or an exception code to rstatus) and retires the op.
module multdiv_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 40,
    // Must be wide enough to hold TIMEOUT_CYCLES - 1.
    parameter int unsigned CNT_W          = 6,
    parameter int unsigned RSTATUS_REG    = 30,
    parameter int unsigned MUL_EXC_CODE   = 4,
    parameter int unsigned DIV_EXC_CODE   = 5
) (
    input  logic        clock,
    input  logic        reset,
    // Issue from DX
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic [4:0]  issue_rd,
    input  logic        flush,
    // Multiply/divide unit
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_operand_a,
    output logic [31:0] md_operand_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    // Pipeline control
    output logic        stall,
    // Regfile write port
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    input  logic        wb_accept,
    output logic        retire,
    output logic        busy
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StWb    = 2'd3;

    localparam logic [CNT_W-1:0] CntLast  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]       RstatReg = 5'(RSTATUS_REG);
    localparam logic [31:0]      MulCode  = 32'(MUL_EXC_CODE);
    localparam logic [31:0]      DivCode  = 32'(DIV_EXC_CODE);

    logic [1:0]       state_q, state_d;
    logic             op_div_q, op_div_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      opa_q, opa_d;
    logic [31:0]      opb_q, opb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      result_q, result_d;
    logic             exc_q, exc_d;

    logic in_start;
    logic in_wb;
    logic wr_needed;
    logic retire_raw;

    assign in_start = (state_q == StStart);
    assign in_wb    = (state_q == StWb);

    // Exceptions always go to rstatus; a clean result to r0 needs no write.
    assign wr_needed  = exc_q | (rd_q != 5'd0);
    assign retire_raw = in_wb & (wb_accept | ~wr_needed);

    // Next-state and latch updates; flush aborts any busy state without a write.
    always_comb begin
        state_d  = state_q;
        op_div_d = op_div_q;
        rd_d     = rd_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        case (state_q)
            StIdle: begin
                if (issue_valid) begin
                    op_div_d = issue_is_div;
                    rd_d     = issue_rd;
                    opa_d    = issue_a;
                    opb_d    = issue_b;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    cnt_d    = '0;
                    exc_d    = 1'b0;
                    result_d = '0;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (md_ready) begin
                        result_d = md_result;
                        exc_d    = md_exception;
                        state_d  = StWb;
                    end else if (cnt_q == CntLast) begin
                        // Unit never answered: report it as an exception.
                        exc_d   = 1'b1;
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                if (flush || retire_raw) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and latch registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            op_div_q <= 1'b0;
            rd_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_div_q <= op_div_d;
            rd_q     <= rd_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    // Unit interface: start pulses come straight from START, killed by flush.
    always_comb begin
        md_ctrl_mult = in_start & ~op_div_q & ~flush;
        md_ctrl_div  = in_start & op_div_q & ~flush;
        md_operand_a = opa_q;
        md_operand_b = opb_q;
    end

    // Write-port request; reg/data derive only from latches so they hold steady.
    always_comb begin
        wb_valid = in_wb & wr_needed & ~flush;
        wb_reg   = '0;
        wb_data  = '0;
        if (in_wb) begin
            wb_reg  = exc_q ? RstatReg : rd_q;
            wb_data = exc_q ? (op_div_q ? DivCode : MulCode) : result_q;
        end
        retire = retire_raw & ~flush;
    end

    // Pipeline freeze: DX holds on issue, and while the op is in flight.
    always_comb begin
        stall = 1'b0;
        busy  = (state_q != StIdle);
        case (state_q)
            StIdle:  stall = issue_valid;
            StStart: stall = ~flush;
            StWait:  stall = ~flush;
            StWb:    stall = ~flush & ~retire_raw;
            default: stall = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: a driver plays each operation (including a simple
// model of the mul/div unit), pushing the architecturally expected write into a
// scoreboard; a monitor pops and compares on every retire pulse.
module tb_multdiv_ctrl;

    localparam int TIMEOUT = 40;

    logic        clock;
    logic        reset;
    logic        issue_valid;
    logic        issue_is_div;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic [4:0]  issue_rd;
    logic        flush;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_operand_a;
    logic [31:0] md_operand_b;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ready;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wb_accept;
    logic        retire;
    logic        busy;

    multdiv_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_is_div (issue_is_div),
        .issue_a      (issue_a),
        .issue_b      (issue_b),
        .issue_rd     (issue_rd),
        .flush        (flush),
        .md_ctrl_mult (md_ctrl_mult),
        .md_ctrl_div  (md_ctrl_div),
        .md_operand_a (md_operand_a),
        .md_operand_b (md_operand_b),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_ready     (md_ready),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .wb_accept    (wb_accept),
        .retire       (retire),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // lat: WAIT-cycle index (0 = first WAIT cycle) of md_ready, -1 = never.
    typedef struct {
        bit          is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          lat;
        bit          unit_exc;
        int          acc_delay;
        int          flush_at;
        bit          flush_wb;
        int          reset_at;
        bit          stale;
    } plan_t;

    typedef struct {
        bit          has_write;
        logic [4:0]  rg;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks     = 0;
    int   n_pass       = 0;
    int   exp_retires  = 0;
    int   seen_retires = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic plan_t mk(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input int lat);
        plan_t p;
        p.is_div = is_div; p.a = a; p.b = b; p.rd = rd; p.lat = lat;
        p.unit_exc = 1'b0; p.acc_delay = 0; p.flush_at = -1; p.flush_wb = 1'b0;
        p.reset_at = -1; p.stale = 1'b0;
        return p;
    endfunction

    function automatic bit timed_out(input plan_t p);
        return !(p.lat >= 0 && p.lat < TIMEOUT);
    endfunction

    function automatic int wait_end(input plan_t p);
        return timed_out(p) ? TIMEOUT - 1 : p.lat;
    endfunction

    function automatic bit unit_raises(input plan_t p);
        return p.unit_exc || (p.is_div && p.b == 32'd0);
    endfunction

    // Stand-in for the arithmetic unit.
    function automatic logic [31:0] unit_result(input plan_t p);
        longint prod;
        if (unit_raises(p)) return 32'hDEAD_BEEF;
        if (p.is_div) return 32'(int'(p.a) / int'(p.b));
        prod = longint'(int'(p.a)) * longint'(int'(p.b));
        return prod[31:0];
    endfunction

    // Architectural outcome of one operation.
    function automatic exp_t model(input plan_t p);
        exp_t e;
        logic signed [31:0] q;
        if (timed_out(p) || unit_raises(p)) begin
            e.has_write = 1'b1; e.rg = 5'd30; e.data = p.is_div ? 32'd5 : 32'd4;
        end else if (p.rd == 5'd0) begin
            e.has_write = 1'b0; e.rg = 5'd0; e.data = 32'd0;
        end else begin
            q = $signed(p.a) / $signed(p.b);
            e.has_write = 1'b1; e.rg = p.rd;
            e.data = p.is_div ? q : p.a * p.b;
        end
        return e;
    endfunction

    // Monitor: every retire must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clock);
            #3;
            if (retire === 1'b1) begin
                seen_retires++;
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wb_valid_at_retire", wb_valid, mon_e.has_write);
                    if (mon_e.has_write) begin
                        check("wb_reg", wb_reg, mon_e.rg);
                        check("wb_data", wb_data, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic run_op(input plan_t p);
        int   guard;
        int   endw;
        bit   killed;
        bit   stop;
        exp_t e;
        guard = 0;
        while (busy !== 1'b0 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        check("idle_before_issue", busy, 0);
        e      = model(p);
        endw   = wait_end(p);
        killed = (p.flush_at >= 0 && p.flush_at <= endw) ||
                 (p.reset_at >= 0 && p.reset_at <= endw) || p.flush_wb;
        if (!killed) begin
            exp_q.push_back(e);
            exp_retires++;
        end
        // Issue cycle
        issue_valid = 1'b1; issue_is_div = p.is_div; issue_a = p.a; issue_b = p.b;
        issue_rd = p.rd;
        #1;
        check("stall_on_issue", stall, 1);
        check("no_pulse_in_idle", {md_ctrl_mult, md_ctrl_div}, 0);
        // START cycle: DX garbage must not disturb the latches
        @(negedge clock);
        issue_valid = 1'b0; issue_a = $urandom; issue_b = $urandom;
        issue_rd = 5'($urandom); issue_is_div = 1'($urandom);
        #1;
        check("pulse_mult", md_ctrl_mult, !p.is_div);
        check("pulse_div", md_ctrl_div, p.is_div);
        check("operand_a", md_operand_a, p.a);
        check("operand_b", md_operand_b, p.b);
        check("stall_start", stall, 1);
        check("busy_start", busy, 1);
        @(negedge clock);
        // WAIT cycles
        for (int w = 0; w <= endw; w++) begin
            issue_valid = 1'($urandom_range(0, 1));
            if (w == p.lat) begin
                md_ready = 1'b1; md_exception = unit_raises(p); md_result = unit_result(p);
            end
            if (w == p.flush_at) flush = 1'b1;
            if (w == p.reset_at) reset = 1'b1;
            #1;
            check("no_repulse", {md_ctrl_mult, md_ctrl_div}, 0);
            check("operand_a_hold", md_operand_a, p.a);
            if (w != p.reset_at) begin
                check("stall_wait", stall, !flush);
                check("wb_valid_wait", wb_valid, 0);
            end
            stop = (w == p.flush_at) || (w == p.reset_at);
            @(negedge clock);
            md_ready = 1'b0; md_exception = 1'b0; md_result = $urandom;
            flush = 1'b0; reset = 1'b0; issue_valid = 1'b0;
            if (stop) break;
        end
        if (killed && !p.flush_wb) begin
            #1;
            check("abort_busy", busy, 0);
            check("abort_stall", stall, 0);
            check("abort_wb_valid", wb_valid, 0);
            check("abort_retire", retire, 0);
            if (p.reset_at >= 0) begin
                check("rst_operand_a", md_operand_a, 0);
                check("rst_operand_b", md_operand_b, 0);
                check("rst_wb_reg", wb_reg, 0);
                check("rst_wb_data", wb_data, 0);
                check("rst_pulse", {md_ctrl_mult, md_ctrl_div}, 0);
            end
            if (p.stale) begin
                repeat (4) @(negedge clock);
                md_ready = 1'b1; md_result = $urandom;
                #1;
                check("stale_busy", busy, 0);
                @(negedge clock);
                md_ready = 1'b0;
                #1;
                check("stale_busy_after", busy, 0);
                check("stale_wb_valid", wb_valid, 0);
            end
            return;
        end
        // WB
        if (p.flush_wb) begin
            flush = 1'b1; wb_accept = 1'b1;
            #1;
            check("flush_wb_valid", wb_valid, 0);
            check("flush_wb_retire", retire, 0);
            check("flush_wb_stall", stall, 0);
            @(negedge clock);
            flush = 1'b0; wb_accept = 1'b0;
            #1;
            check("flush_wb_busy", busy, 0);
            return;
        end
        if (!e.has_write) begin
            wb_accept = 1'($urandom_range(0, 1)); issue_valid = 1'b1;
            #1;
            check("r0_wb_valid", wb_valid, 0);
            check("r0_retire", retire, 1);
            check("r0_stall", stall, 0);
            @(negedge clock);
            wb_accept = 1'b0; issue_valid = 1'b0;
            #1;
            check("r0_busy_after", busy, 0);
            return;
        end
        for (int k = 0; k <= p.acc_delay; k++) begin
            wb_accept = (k == p.acc_delay);
            issue_valid = (k == p.acc_delay);
            #1;
            check("wb_valid_hold", wb_valid, 1);
            check("wb_reg_hold", wb_reg, e.rg);
            check("wb_data_hold", wb_data, e.data);
            check("wb_retire", retire, k == p.acc_delay);
            check("wb_stall", stall, k != p.acc_delay);
            @(negedge clock);
            wb_accept = 1'b0; issue_valid = 1'b0;
        end
        #1;
        check("busy_after_retire", busy, 0);
    endtask

    function automatic plan_t rand_plan();
        plan_t p;
        int    endw;
        int    r;
        p = mk(1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom), 0);
        if ($urandom_range(0, 3) == 0) p.a = 32'($urandom_range(0, 1000));
        if (p.is_div && $urandom_range(0, 5) == 0) p.b = 32'd0;
        if (p.b == 32'hFFFF_FFFF) p.b = 32'd1;
        if ($urandom_range(0, 5) == 0) p.rd = 5'd0;
        r = int'($urandom_range(0, 9));
        if (r == 0)      p.lat = -1;
        else if (r == 1) p.lat = TIMEOUT - 1;
        else             p.lat = int'($urandom_range(0, TIMEOUT - 2));
        p.unit_exc  = ($urandom_range(0, 7) == 0);
        p.acc_delay = int'($urandom_range(0, 3));
        endw = wait_end(p);
        r = int'($urandom_range(0, 11));
        if (r == 0) begin
            p.flush_at = int'($urandom_range(0, endw));
            p.stale    = 1'($urandom_range(0, 1));
        end else if (r == 1) begin
            p.flush_wb = 1'b1;
        end else if (r == 2) begin
            p.reset_at = int'($urandom_range(0, endw));
        end
        return p;
    endfunction

    initial begin
        plan_t p;
        reset = 1'b1; issue_valid = 1'b0; issue_is_div = 1'b0; issue_a = '0; issue_b = '0;
        issue_rd = '0; flush = 1'b0; md_result = '0; md_exception = 1'b0; md_ready = 1'b0;
        wb_accept = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("reset_busy", busy, 0);
        check("reset_stall", stall, 0);
        check("reset_pulse", {md_ctrl_mult, md_ctrl_div}, 0);
        check("reset_wb_valid", wb_valid, 0);
        check("reset_retire", retire, 0);
        check("reset_operand_a", md_operand_a, 0);
        check("reset_wb_reg", wb_reg, 0);
        check("reset_wb_data", wb_data, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Mult 7 * -3 to r5, ready 33 cycles after the pulse
        run_op(mk(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32));
        // Divide by zero: unit exception lands in rstatus
        run_op(mk(1'b1, 32'd100, 32'd0, 5'd9, 6));
        // Write port withheld for 3 cycles
        p = mk(1'b0, 32'd12345, 32'd678, 5'd12, 4);
        p.acc_delay = 3;
        run_op(p);
        // Unit never answers: timeout exception
        p = mk(1'b0, 32'd3, 32'd4, 5'd7, -1);
        p.acc_delay = 1;
        run_op(p);
        // Ready on the last WAIT cycle beats the timeout
        run_op(mk(1'b1, 32'd1000, 32'd9, 5'd11, TIMEOUT - 1));
        // Ready in the first WAIT cycle
        run_op(mk(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0));
        // Flush in WAIT, stale ready, then a fresh div
        p = mk(1'b0, 32'd55, 32'd66, 5'd3, 20);
        p.flush_at = 10;
        p.stale    = 1'b1;
        run_op(p);
        run_op(mk(1'b1, 32'hFFFF_FC18, 32'd7, 5'd4, 2));
        // Flush coinciding with md_ready
        p = mk(1'b1, 32'd80, 32'd3, 5'd13, 5);
        p.flush_at = 5;
        run_op(p);
        // Flush in WB with wb_accept high
        p = mk(1'b0, 32'd9, 32'd9, 5'd14, 3);
        p.flush_wb = 1'b1;
        run_op(p);
        // Clean result to r0: no write, immediate retire
        run_op(mk(1'b0, 32'd6, 32'd7, 5'd0, 3));
        // Reset in WAIT
        p = mk(1'b0, 32'd21, 32'd2, 5'd8, 20);
        p.reset_at = 5;
        run_op(p);

        for (int i = 0; i < 60; i++) begin
            run_op(rand_plan());
        end

        repeat (3) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);
        check("retire_count", seen_retires, exp_retires);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
